// File: rtl/display_sched_pkg.sv
// rtl/display_sched_pkg.sv - shared types and widths for the display write scheduler
package display_sched_pkg;

  localparam int DISP_ADDR_W = 20;
  localparam int DISP_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PULSE     = 2'd1,
    WAIT_BUSY = 2'd2,
    FLIP_WAIT = 2'd3
  } sched_state_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with registered read data on pop
module sync_fifo #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  localparam logic [AW-1:0] PTR_ONE  = 1;
  localparam logic [AW:0]   LVL_ONE  = 1;
  localparam logic [AW:0]   LVL_FULL = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == LVL_FULL);
  assign empty   = (count == '0);
  assign level   = count;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Storage array; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers, occupancy and the registered head word handed out on pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      pop_data <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop) begin
        rd_ptr   <= rd_ptr + PTR_ONE;
        pop_data <= mem[rd_ptr];
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + LVL_ONE;
        2'b01:   count <= count - LVL_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/display_write_scheduler.sv
// rtl/display_write_scheduler.sv - buffers CPU pixel writes and sequences display writes and flips
module display_write_scheduler
  import display_sched_pkg::*;
#(
  parameter int FIFO_DEPTH      = 8,
  parameter int WR_PULSE_CYCLES = 3,
  parameter int FLIP_ON_VBLANK  = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        req_valid,
  input  logic [DISP_ADDR_W-1:0]      req_addr,
  input  logic [DISP_DATA_W-1:0]      req_data,
  output logic                        req_ready,
  input  logic                        flip_req,
  input  logic                        vblank,
  input  logic                        display_busy,
  output logic [DISP_ADDR_W-1:0]      display_addr,
  output logic [DISP_DATA_W-1:0]      display_data,
  output logic                        display_wr,
  output logic                        display_flip_framebuffer,
  output logic                        flip_pending,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        idle
);

  localparam int WORD_W = DISP_ADDR_W + DISP_DATA_W;
  localparam logic [2:0] PULSE_LOAD = 3'(WR_PULSE_CYCLES - 1);

  sched_state_t      state;
  logic [2:0]        pulse_cnt;
  logic              prev_vblank;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;
  logic              flip_fire;
  logic [WORD_W-1:0] head_word;

  assign req_ready = !fifo_full;
  assign push      = req_valid && req_ready;
  // The FSM only consumes an entry when it can start a write right away.
  assign pop       = (state == IDLE) && !fifo_empty && !display_busy;
  // With vblank gating disabled the flip goes out on the first FLIP_WAIT cycle.
  assign flip_fire = (state == FLIP_WAIT) &&
                     ((FLIP_ON_VBLANK == 0) || (vblank && !prev_vblank));

  assign display_addr = head_word[WORD_W-1:DISP_DATA_W];
  assign display_data = head_word[DISP_DATA_W-1:0];
  assign idle         = fifo_empty && (state == IDLE) && !flip_pending;

  sync_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data ({req_addr, req_data}),
    .pop       (pop),
    .pop_data  (head_word),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  // Write/flip sequencer: strobe timing, busy handshake, flip flag and vblank edge detect.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state                    <= IDLE;
      pulse_cnt                <= '0;
      display_wr               <= 1'b0;
      display_flip_framebuffer <= 1'b0;
      flip_pending             <= 1'b0;
      prev_vblank              <= 1'b1;
    end else begin
      prev_vblank              <= vblank;
      display_flip_framebuffer <= 1'b0;

      // A request landing on the issuing cycle re-arms the flag for the next frame.
      if (flip_fire)     flip_pending <= flip_req;
      else if (flip_req) flip_pending <= 1'b1;

      case (state)
        IDLE: begin
          if (pop) begin
            display_wr <= 1'b1;
            pulse_cnt  <= PULSE_LOAD;
            state      <= PULSE;
          end else if (flip_pending && fifo_empty) begin
            state <= FLIP_WAIT;
          end
        end
        PULSE: begin
          if (pulse_cnt == 3'd0) begin
            display_wr <= 1'b0;
            state      <= WAIT_BUSY;
          end else begin
            pulse_cnt <= pulse_cnt - 3'd1;
          end
        end
        WAIT_BUSY: begin
          if (!display_busy) state <= IDLE;
        end
        FLIP_WAIT: begin
          if (flip_fire) begin
            display_flip_framebuffer <= 1'b1;
            state                    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_display_write_scheduler.sv
// tb/tb_display_write_scheduler.sv - directed self-checking bench for display_write_scheduler
module tb_display_write_scheduler;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic [19:0] req_addr;
  logic [15:0] req_data;
  logic        req_ready;
  logic        flip_req;
  logic        vblank;
  logic        display_busy;
  logic [19:0] display_addr;
  logic [15:0] display_data;
  logic        display_wr;
  logic        display_flip_framebuffer;
  logic        flip_pending;
  logic [3:0]  fifo_level;
  logic        idle;

  int errors = 0;
  int checks = 0;

  display_write_scheduler #(
    .FIFO_DEPTH      (8),
    .WR_PULSE_CYCLES (3),
    .FLIP_ON_VBLANK  (1)
  ) dut (
    .clk                      (clk),
    .reset                    (reset),
    .req_valid                (req_valid),
    .req_addr                 (req_addr),
    .req_data                 (req_data),
    .req_ready                (req_ready),
    .flip_req                 (flip_req),
    .vblank                   (vblank),
    .display_busy             (display_busy),
    .display_addr             (display_addr),
    .display_data             (display_data),
    .display_wr               (display_wr),
    .display_flip_framebuffer (display_flip_framebuffer),
    .flip_pending             (flip_pending),
    .fifo_level               (fifo_level),
    .idle                     (idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // All sampling and driving happens on the falling edge.
  task automatic tick;
    @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b1; req_valid = 1'b0; req_addr = '0; req_data = '0;
    flip_req = 1'b0; vblank = 1'b0; display_busy = 1'b0;
    tick; tick;
    checks++;
    if (display_wr !== 1'b0 || display_flip_framebuffer !== 1'b0 || flip_pending !== 1'b0) begin
      errors++; $display("FAIL reset_strobes: wr=%b flip=%b pend=%b expected 0 0 0",
                         display_wr, display_flip_framebuffer, flip_pending);
    end
    checks++;
    if (req_ready !== 1'b1 || fifo_level !== 4'd0) begin
      errors++; $display("FAIL reset_fifo: ready=%b level=%0d expected 1 0", req_ready, fifo_level);
    end
    checks++;
    if (display_addr !== 20'h0 || display_data !== 16'h0) begin
      errors++; $display("FAIL reset_bus: addr=%h data=%h expected 0 0", display_addr, display_data);
    end
    reset = 1'b0;
    tick;
  endtask

  task automatic test_single_write;
    int first = -1;
    int cnt = 0;
    bit bad = 0;
    req_valid = 1'b1; req_addr = 20'h00123; req_data = 16'hBEEF;
    tick;
    req_valid = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      if (display_wr) begin
        if (first < 0) first = i;
        cnt++;
        if (display_addr !== 20'h00123 || display_data !== 16'hBEEF) bad = 1;
      end
      tick;
    end
    checks++;
    if (first != 2) begin errors++; $display("FAIL single_latency: rise at %0d expected 2", first); end
    checks++;
    if (cnt != 3) begin errors++; $display("FAIL single_width: %0d cycles expected 3", cnt); end
    checks++;
    if (bad) begin errors++; $display("FAIL single_bus: addr/data unstable, expected 00123/beef"); end
    checks++;
    if (idle !== 1'b1) begin errors++; $display("FAIL single_idle: idle=%b expected 1", idle); end
  endtask

  task automatic test_full_and_drain;
    int nw = 0;
    int last_t = -1;
    bit order_bad = 0;
    bit gap_bad = 0;
    bit acc9 = 0;
    logic prev_wr = 1'b0;
    display_busy = 1'b1;
    for (int k = 0; k < 8; k++) begin
      req_valid = 1'b1; req_addr = 20'h10000 | 20'(k); req_data = 16'hA000 | 16'(k);
      tick;
    end
    req_addr = 20'h10008; req_data = 16'hA008;
    checks++;
    if (req_ready !== 1'b0 || fifo_level !== 4'd8) begin
      errors++; $display("FAIL full_flags: ready=%b level=%0d expected 0 8", req_ready, fifo_level);
    end
    tick; tick;
    checks++;
    if (fifo_level !== 4'd8 || display_wr !== 1'b0) begin
      errors++; $display("FAIL full_hold: level=%0d wr=%b expected 8 0", fifo_level, display_wr);
    end
    display_busy = 1'b0;
    for (int t = 0; t < 80; t++) begin
      if (display_wr && !prev_wr) begin
        if (display_addr !== (20'h10000 | 20'(nw)) || display_data !== (16'hA000 | 16'(nw))) order_bad = 1;
        if (last_t >= 0 && t - last_t != 5) gap_bad = 1;
        last_t = t;
        nw++;
      end
      prev_wr = display_wr;
      if (acc9) req_valid = 1'b0;
      else if (req_valid && req_ready) acc9 = 1;
      tick;
    end
    checks++;
    if (nw != 9) begin errors++; $display("FAIL drain_count: %0d writes expected 9", nw); end
    checks++;
    if (order_bad) begin errors++; $display("FAIL drain_order: writes out of order, expected 10000..10008"); end
    checks++;
    if (gap_bad) begin errors++; $display("FAIL drain_spacing: gap not 5 cycles, expected 5"); end
    checks++;
    if (!acc9 || fifo_level !== 4'd0) begin
      errors++; $display("FAIL drain_ninth: accepted=%0d level=%0d expected 1 0", acc9, fifo_level);
    end
  endtask

  task automatic test_busy_during_pulse;
    int rise_a = -1;
    int rise_b = -1;
    int cnt_a = 0;
    logic prev_wr = 1'b0;
    display_busy = 1'b0;
    req_valid = 1'b1; req_addr = 20'h20001; req_data = 16'h1111;
    tick;
    req_addr = 20'h20002; req_data = 16'h2222;
    tick;
    req_valid = 1'b0;
    checks++;
    if (fifo_level !== 4'd1) begin
      errors++; $display("FAIL pushpop_level: level=%0d expected 1", fifo_level);
    end
    for (int t = 2; t <= 30; t++) begin
      if (display_wr && display_addr === 20'h20001) cnt_a++;
      if (display_wr && !prev_wr) begin
        if (display_addr === 20'h20001 && rise_a < 0) rise_a = t;
        if (display_addr === 20'h20002 && display_data === 16'h2222 && rise_b < 0) rise_b = t;
      end
      prev_wr = display_wr;
      if (t == 3) display_busy = 1'b1;
      if (t == 13) display_busy = 1'b0;
      tick;
    end
    checks++;
    if (rise_a != 2 || cnt_a != 3) begin
      errors++; $display("FAIL busy_pulse: rise=%0d width=%0d expected 2 3", rise_a, cnt_a);
    end
    checks++;
    if (rise_b != 15) begin errors++; $display("FAIL busy_next: rise=%0d expected 15", rise_b); end
  endtask

  task automatic test_flip_after_drain;
    int nw = 0;
    int flips = 0;
    int flip_t = -1;
    int rise_t = -1;
    bit order_bad = 0;
    logic prev_wr = 1'b0;
    display_busy = 1'b0; vblank = 1'b0;
    for (int k = 0; k < 3; k++) begin
      req_valid = 1'b1; req_addr = 20'h30000 | 20'(k); req_data = 16'hC000 | 16'(k);
      tick;
    end
    req_valid = 1'b0; flip_req = 1'b1;
    tick;
    flip_req = 1'b0;
    for (int t = 0; t < 25; t++) begin
      if (display_wr && !prev_wr) nw++;
      prev_wr = display_wr;
      if (display_flip_framebuffer) flips++;
      tick;
    end
    checks++;
    if (nw != 3 || flips != 0) begin
      errors++; $display("FAIL flip_hold: writes=%0d flips=%0d expected 3 0", nw, flips);
    end
    checks++;
    if (flip_pending !== 1'b1 || idle !== 1'b0) begin
      errors++; $display("FAIL flip_pend: pend=%b idle=%b expected 1 0", flip_pending, idle);
    end
    nw = 0;
    for (int k = 0; k < 2; k++) begin
      req_valid = 1'b1; req_addr = 20'h30010 | 20'(k); req_data = 16'hD000 | 16'(k);
      tick;
    end
    req_valid = 1'b0;
    for (int t = 0; t < 6; t++) begin
      if (display_wr) nw++;
      tick;
    end
    checks++;
    if (nw != 0 || fifo_level !== 4'd2) begin
      errors++; $display("FAIL flipwait_hold: wr_cycles=%0d level=%0d expected 0 2", nw, fifo_level);
    end
    vblank = 1'b1;
    for (int t = 0; t <= 20; t++) begin
      if (display_flip_framebuffer) begin flips++; if (flip_t < 0) flip_t = t; end
      if (display_wr && !prev_wr) begin
        if (rise_t < 0) rise_t = t;
        if (display_addr !== (20'h30010 | 20'(nw)) || display_data !== (16'hD000 | 16'(nw))) order_bad = 1;
        nw++;
      end
      prev_wr = display_wr;
      tick;
    end
    vblank = 1'b0;
    checks++;
    if (flips != 1 || flip_t != 1) begin
      errors++; $display("FAIL flip_pulse: count=%0d at=%0d expected 1 1", flips, flip_t);
    end
    checks++;
    if (flip_pending !== 1'b0) begin errors++; $display("FAIL flip_clear: pend=%b expected 0", flip_pending); end
    checks++;
    if (nw != 2 || rise_t != 2 || order_bad) begin
      errors++; $display("FAIL post_flip_writes: count=%0d first=%0d order_bad=%0d expected 2 2 0",
                         nw, rise_t, order_bad);
    end
    tick;
  endtask

  task automatic test_flip_merge;
    int flips = 0;
    vblank = 1'b0;
    flip_req = 1'b1; tick; flip_req = 1'b0; tick;
    flip_req = 1'b1; tick; flip_req = 1'b0;
    for (int t = 0; t < 8; t++) begin
      if (display_flip_framebuffer) flips++;
      tick;
    end
    checks++;
    if (flip_pending !== 1'b1 || flips != 0) begin
      errors++; $display("FAIL merge_wait: pend=%b flips=%0d expected 1 0", flip_pending, flips);
    end
    vblank = 1'b1;
    for (int t = 0; t < 10; t++) begin
      if (display_flip_framebuffer) flips++;
      tick;
    end
    vblank = 1'b0; tick; vblank = 1'b1;
    for (int t = 0; t < 6; t++) begin
      if (display_flip_framebuffer) flips++;
      tick;
    end
    checks++;
    if (flips != 1 || flip_pending !== 1'b0) begin
      errors++; $display("FAIL merge_count: flips=%0d pend=%b expected 1 0", flips, flip_pending);
    end
    flips = 0;
    reset = 1'b1; tick; reset = 1'b0;
    flip_req = 1'b1; tick; flip_req = 1'b0;
    for (int t = 0; t < 10; t++) begin
      if (display_flip_framebuffer) flips++;
      tick;
    end
    checks++;
    if (flips != 0 || flip_pending !== 1'b1) begin
      errors++; $display("FAIL reset_vblank: flips=%0d pend=%b expected 0 1", flips, flip_pending);
    end
    vblank = 1'b0; tick; vblank = 1'b1;
    for (int t = 0; t < 6; t++) begin
      if (display_flip_framebuffer) flips++;
      tick;
    end
    vblank = 1'b0;
    checks++;
    if (flips != 1) begin errors++; $display("FAIL reset_vblank_edge: flips=%0d expected 1", flips); end
    tick;
  endtask

  task automatic test_reset_mid_pulse;
    int nw = 0;
    display_busy = 1'b1;
    for (int k = 0; k < 5; k++) begin
      req_valid = 1'b1; req_addr = 20'h40000 | 20'(k); req_data = 16'hE000 | 16'(k);
      tick;
    end
    req_valid = 1'b0; display_busy = 1'b0; flip_req = 1'b1;
    tick;
    flip_req = 1'b0;
    tick;
    checks++;
    if (display_wr !== 1'b1 || fifo_level !== 4'd4 || flip_pending !== 1'b1) begin
      errors++; $display("FAIL pre_reset: wr=%b level=%0d pend=%b expected 1 4 1",
                         display_wr, fifo_level, flip_pending);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (display_wr !== 1'b0 || fifo_level !== 4'd0 || flip_pending !== 1'b0) begin
      errors++; $display("FAIL async_reset: wr=%b level=%0d pend=%b expected 0 0 0",
                         display_wr, fifo_level, flip_pending);
    end
    tick;
    reset = 1'b0;
    for (int t = 0; t < 20; t++) begin
      if (display_wr || display_flip_framebuffer) nw++;
      tick;
    end
    checks++;
    if (nw != 0 || idle !== 1'b1) begin
      errors++; $display("FAIL after_reset: active_cycles=%0d idle=%b expected 0 1", nw, idle);
    end
  endtask

  initial begin
    test_reset;
    test_single_write;
    test_full_and_drain;
    test_busy_during_pulse;
    test_flip_after_drain;
    test_flip_merge;
    test_reset_mid_pulse;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
